// File: rtl/jericalla_sequencer.sv
// Jericalla program sequencer: buffers up to PROG_DEPTH instruction words and
// issues each one as a masked settle cycle followed by a commit cycle.
module jericalla_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int PTR_W      = 4,
  parameter int INSTR_W    = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               clear,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [PTR_W:0]     prog_len,
  output logic [PTR_W-1:0]   pc,
  output logic [INSTR_W-1:0] instruction
);

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, FINISH} state_t;

  localparam logic [PTR_W:0]   DEPTH_L = PROG_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   LEN_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PC_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [PTR_W:0]     prog_len_q, prog_len_d;
  logic [PTR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               abrt_q, abrt_d;
  logic [INSTR_W-1:0] prog_q [PROG_DEPTH];

  logic               accept;
  logic [PTR_W:0]     run_len;
  logic [PTR_W-1:0]   last_pc;
  logic [INSTR_W-1:0] first_word;
  logic [INSTR_W-1:0] cur_word;
  logic [INSTR_W-1:0] nxt_word;

  // Load handshake, effective run length and the words feeding the issue mux.
  // A word loaded in the same cycle as start is forwarded straight to slot 0.
  always_comb begin
    load_ready = (state_q == IDLE) && (prog_len_q != DEPTH_L) && !clear;
    accept     = load_valid && load_ready;
    run_len    = clear ? '0 : (accept ? prog_len_q + LEN_ONE : prog_len_q);
    last_pc    = prog_len_q[PTR_W-1:0] - PC_ONE;
    first_word = (accept && prog_len_q == '0) ? load_instr : prog_q[0];
    cur_word   = prog_q[pc_q];
    nxt_word   = prog_q[pc_q + PC_ONE];
  end

  // Next-state logic; instruction is computed one cycle ahead and registered.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    pc_d       = pc_q;
    instr_d    = '0;
    abrt_d     = abrt_q;
    unique case (state_q)
      IDLE: begin
        abrt_d = 1'b0;
        if (clear)       prog_len_d = '0;
        else if (accept) prog_len_d = prog_len_q + LEN_ONE;
        if (start) begin
          if (run_len != '0) begin
            state_d = SETTLE;
            pc_d    = '0;
            instr_d = {first_word[INSTR_W-1:1], 1'b0};
          end else begin
            state_d = FINISH;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = FINISH;
          abrt_d  = 1'b1;
        end else begin
          state_d = COMMIT;
          instr_d = cur_word;
        end
      end
      COMMIT: begin
        if (abort) begin
          state_d = FINISH;
          abrt_d  = 1'b1;
        end else if (pc_q == last_pc) begin
          state_d = FINISH;
        end else begin
          state_d = SETTLE;
          pc_d    = pc_q + PC_ONE;
          instr_d = {nxt_word[INSTR_W-1:1], 1'b0};
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      abrt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      abrt_q     <= abrt_d;
    end
  end

  // Program buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && accept && !clear) prog_q[prog_len_q[PTR_W-1:0]] <= load_instr;
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH) && !abrt_q;
  assign aborted     = (state_q == FINISH) && abrt_q;
  assign prog_len    = prog_len_q;
  assign pc          = pc_q;
  assign instruction = instr_q;

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Directed bench for the Jericalla program sequencer.
module tb_jericalla_sequencer;

  logic        clk = 1'b0;
  logic        rst, load_valid, clear, start, abort;
  logic [16:0] load_instr;
  logic        load_ready, busy, done, aborted;
  logic [4:0]  prog_len;
  logic [3:0]  pc;
  logic [16:0] instruction;

  int checks   = 0;
  int failures = 0;

  jericalla_sequencer #(.PROG_DEPTH(16), .PTR_W(4), .INSTR_W(17)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_instr(load_instr), .clear(clear), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .prog_len(prog_len),
    .pc(pc), .instruction(instruction)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [16:0] w);
    load_valid = 1'b1;
    load_instr = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_valid = 1'b0; load_instr = '0; clear = 1'b0;
    start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, aborted, load_ready} !== 4'b0001) begin
      failures++; $display("FAIL reset_flags got=%b exp=0001", {busy, done, aborted, load_ready});
    end
    checks++;
    if (prog_len !== 5'd0 || pc !== 4'd0 || instruction !== 17'd0) begin
      failures++; $display("FAIL reset_regs len=%0d pc=%0d instr=%h exp 0/0/0", prog_len, pc, instruction);
    end
  endtask

  task automatic test_basic;
    logic [16:0] exp_i [6];
    logic [3:0]  exp_pc [6];
    exp_i  = '{17'h1A2B4, 17'h1A2B5, 17'h0C3C0, 17'h0C3C0, 17'h1FFFE, 17'h1FFFF};
    exp_pc = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2};
    load_word(17'h1A2B5); load_word(17'h0C3C0); load_word(17'h1FFFF);
    checks++;
    if (prog_len !== 5'd3) begin failures++; $display("FAIL basic_len got=%0d exp=3", prog_len); end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instruction !== exp_i[i] || busy !== 1'b1 || done !== 1'b0 || pc !== exp_pc[i]) begin
        failures++;
        $display("FAIL basic_issue c%0d instr=%h busy=%b done=%b pc=%0d exp instr=%h busy=1 done=0 pc=%0d",
                 i + 1, instruction, busy, done, pc, exp_i[i], exp_pc[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || instruction !== 17'd0 || aborted !== 1'b0) begin
      failures++; $display("FAIL basic_done done=%b busy=%b instr=%h ab=%b exp 1/1/0/0", done, busy, instruction, aborted);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pc !== 4'd2 || prog_len !== 5'd3) begin
      failures++; $display("FAIL basic_idle busy=%b done=%b pc=%0d len=%0d exp 0/0/2/3", busy, done, pc, prog_len);
    end
  endtask

  task automatic test_full;
    logic [16:0] w0, w15, i1, i32;
    int c;
    do_clear();
    checks++;
    if (prog_len !== 5'd0) begin failures++; $display("FAIL full_clear len=%0d exp=0", prog_len); end
    for (int i = 0; i < 16; i++) begin
      logic [16:0] w;
      w = 17'(i * 17'h0ABC + 1);
      if (i == 0)  w0 = w;
      if (i == 15) w15 = w;
      load_word(w);
    end
    checks++;
    if (load_ready !== 1'b0 || prog_len !== 5'd16) begin
      failures++; $display("FAIL full_ready ready=%b len=%0d exp 0/16", load_ready, prog_len);
    end
    load_word(17'h12345);
    checks++;
    if (prog_len !== 5'd16) begin failures++; $display("FAIL full_overflow len=%0d exp=16", prog_len); end
    start = 1'b1; tick(); start = 1'b0;
    c = 1; i1 = '0; i32 = '0;
    while (done !== 1'b1 && c < 100) begin
      if (c == 1)  i1  = instruction;
      if (c == 32) i32 = instruction;
      tick(); c++;
    end
    checks++;
    if (c !== 33) begin failures++; $display("FAIL full_done_cycle got=%0d exp=33", c); end
    checks++;
    if (i1 !== {w0[16:1], 1'b0} || i32 !== w15) begin
      failures++; $display("FAIL full_words first=%h last=%h exp %h %h", i1, i32, {w0[16:1], 1'b0}, w15);
    end
    tick();
  endtask

  task automatic test_empty;
    do_clear();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b1 || instruction !== 17'd0) begin
      failures++; $display("FAIL empty_c1 busy=%b done=%b instr=%h exp 1/1/0", busy, done, instruction);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || instruction !== 17'd0) begin
      failures++; $display("FAIL empty_c2 busy=%b done=%b instr=%h exp 0/0/0", busy, done, instruction);
    end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 1'b0;
    do_clear();
    load_word(17'h0AAAB); load_word(17'h15555); load_word(17'h00F01);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    checks++;
    if (instruction !== 17'h15554) begin
      failures++; $display("FAIL abort_settle instr=%h exp=15554", instruction);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    if (instruction === 17'h15555) seen = 1'b1;
    checks++;
    if (instruction !== 17'd0 || aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL abort_finish instr=%h ab=%b done=%b busy=%b exp 0/1/0/1", instruction, aborted, done, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (instruction === 17'h15555) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0 || aborted !== 1'b0) begin
      failures++; $display("FAIL abort_after seen=%b busy=%b ab=%b exp 0/0/0", seen, busy, aborted);
    end
  endtask

  task automatic test_clear_and_ignore;
    int c;
    clear = 1'b1; load_valid = 1'b1; load_instr = 17'h1F0F1;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin failures++; $display("FAIL clear_ready got=%b exp=0", load_ready); end
    tick();
    clear = 1'b0; load_valid = 1'b0;
    checks++;
    if (prog_len !== 5'd0) begin failures++; $display("FAIL clear_load len=%0d exp=0", prog_len); end
    load_word(17'h00003); load_word(17'h00005);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    c = 3;
    while (done !== 1'b1 && c < 100) begin tick(); c++; end
    checks++;
    if (c !== 5 || prog_len !== 5'd2) begin
      failures++; $display("FAIL ignore_start done_cycle=%0d len=%0d exp 5/2", c, prog_len);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_start_with_load;
    do_clear();
    load_valid = 1'b1; load_instr = 17'h0ABCD; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    checks++;
    if (instruction !== 17'h0ABCC || prog_len !== 5'd1) begin
      failures++; $display("FAIL startload_c1 instr=%h len=%0d exp 0abcc/1", instruction, prog_len);
    end
    tick();
    checks++;
    if (instruction !== 17'h0ABCD) begin failures++; $display("FAIL startload_c2 instr=%h exp=0abcd", instruction); end
    tick();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL startload_done done=%b exp=1", done); end
    tick();
  endtask

  task automatic test_reset_midrun;
    logic bad;
    bad = 1'b0;
    do_clear();
    load_word(17'h00011); load_word(17'h00021); load_word(17'h00031);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (instruction !== 17'h00031) begin failures++; $display("FAIL rstrun_commit instr=%h exp=00031", instruction); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || instruction !== 17'd0 || prog_len !== 5'd0 || done !== 1'b0 || aborted !== 1'b0) begin
      failures++; $display("FAIL rstrun_state busy=%b instr=%h len=%0d done=%b ab=%b exp all 0",
                           busy, instruction, prog_len, done, aborted);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0 || aborted !== 1'b0 || instruction !== 17'd0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL rstrun_quiet got=%b exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_empty();
    test_abort();
    test_clear_and_ignore();
    test_start_with_load();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jericalla_sequencer.md
Name: jericalla_sequencer

Overview:
Program sequencer for the Jericalla ROM→ALU→RAM datapath. It buffers a short program of 17-bit instruction words, then issues them one at a time onto the datapath instruction bus. Each word gets a settle cycle with write-enable masked, followed by a commit cycle with the word's own enable bit. It replaces hand-driving of the instruction bus with a load/start/done handshake.

Parameters:
- PROG_DEPTH, 16, number of instruction slots in the program buffer (power of two).
- PTR_W, 4, width of the load and issue pointers; equals log2(PROG_DEPTH).
- INSTR_W, 17, instruction word width. Fields: [16:13] RAM addr, [12:9] opcode, [8:5] dir1, [4:1] dir2, [0] EN.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- load_valid, input, 1, load_instr is valid.
- load_ready, output, 1, the buffer accepts a word this cycle.
- load_instr, input, INSTR_W, instruction word to append to the program.
- clear, input, 1, empties the program buffer; honoured in IDLE only.
- start, input, 1, single-cycle request to run the loaded program.
- abort, input, 1, stops the running program.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a run ends normally.
- aborted, output, 1, one-cycle pulse when a run ends because of abort.
- prog_len, output, PTR_W+1, number of words currently loaded (0..PROG_DEPTH).
- pc, output, PTR_W, index of the word currently on instr_out.
- instruction, output, INSTR_W, drives the datapath instruction input.

Behaviour:
- Reset: state=IDLE; prog_len=0; pc=0; instruction=0; busy=0; done=0; aborted=0; load_ready=1. Buffer contents are don't-care.
- States: IDLE, SETTLE, COMMIT, FINISH.
- Loading (IDLE only):
  - load_ready = (state==IDLE) && (prog_len<PROG_DEPTH) && !clear.
  - On load_valid && load_ready: write buf[prog_len] and increment prog_len.
  - clear in IDLE sets prog_len=0 and takes priority over a same-cycle load.
  - clear outside IDLE is ignored.
- IDLE, start:
  - start && prog_len>0 → SETTLE with pc=0.
  - start && prog_len==0 → FINISH directly; nothing is issued and done pulses.
  - If start and load_valid arrive in the same IDLE cycle, the load is accepted first. The run length includes that word.
- SETTLE:
  - instruction = {buf[pc][16:1], 1'b0}, so write-enable is masked while the ROM/ALU path settles.
  - Always → COMMIT next cycle.
- COMMIT:
  - instruction = buf[pc] unmodified, so the RAM writes only if bit0=1.
  - If pc==prog_len-1 → FINISH.
  - Otherwise pc+1 and → SETTLE.
- FINISH: instruction=0; done=1 (or aborted=1) for exactly this cycle; → IDLE. pc holds its last value.
- Throughput: exactly 2 cycles per word. For N words, done is asserted 2N+1 cycles after the start cycle, counting the start edge as cycle 0.
- instruction is registered and changes only on clock edges. Bits [16:1] are identical in the SETTLE and COMMIT cycles of a word.
- Abort:
  - abort in SETTLE or COMMIT → FINISH next cycle with aborted=1 and done=0.
  - When abort occurs in SETTLE, that word's COMMIT (its RAM write) never happens.
  - When abort occurs in COMMIT, that word's write has already been presented and is not retracted.
  - abort in IDLE or FINISH has no effect.
- Ignored inputs: start while busy; start in the FINISH cycle.
- Retention: the program survives a run, so start can be repeated without reloading.
- Reset mid-run: returns to IDLE within one edge with instruction=0 and prog_len=0; no further EN=1 is issued.
- pc wraps mod PROG_DEPTH. It is only incremented while pc<prog_len-1, so it never exceeds prog_len-1.

Test Plan:
1. Reset, load 3 words 0x1A2B5, 0x0C3C0, 0x1FFFF; pulse start → instruction shows 0x1A2B4, 0x1A2B5, 0x0C3C0, 0x0C3C0, 0x1FFFE, 0x1FFFF on cycles 1..6; done=1 on cycle 7; busy=1 on cycles 1..7.
2. Load PROG_DEPTH=16 words → load_ready=0 after the 16th accept and prog_len=16; a 17th load_valid is not accepted; start → done on cycle 33.
3. Start with prog_len=0 → busy=1 and done=1 on cycle 1; instruction stays 0; back in IDLE on cycle 2.
4. 3-word program, abort during the SETTLE of word 1 (cycle 3) → cycle 4 instruction=0 with aborted=1 and done=0; instruction never equals the unmasked form of word 1.
5. clear together with load_valid in IDLE → prog_len=0 and the word is dropped. start during a run → ignored, with run length and done timing unchanged.
6. rst asserted during COMMIT of word 2 → next cycle: IDLE, instruction=0, busy=0, prog_len=0, and no done or aborted pulse.
